// File: rtl/call_dispatcher.sv
// call_dispatcher: lift call latch and sweep scheduler.
// Raw call buttons are synchronized, optionally debounced, and edge-detected
// into a pending mask. A three-state sweep scheduler (IDLE / SWEEP_UP /
// SWEEP_DOWN) picks the next target floor from that mask.
// Optional feature: define CALL_DISPATCHER_DEBOUNCE_EN to add a per-bit
// debounce filter of DEB_CYCLES consecutive equal samples.
// Handshake: target_valid=1 means target_floor names a floor that is still
// pending. There is no ready; the lift controller acknowledges a target by
// opening the doors at that floor, which clears the call.
module call_dispatcher #(
    parameter int N_FLOORS   = 8,
    parameter int DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] call_btn,
    input  logic [2:0] cur_floor,
    input  logic       doors_open,
    output logic [2:0] target_floor,
    output logic       target_valid,
    output logic       dir_up,
    output logic [7:0] pending,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SWEEP_UP   = 2'd1,
        SWEEP_DOWN = 2'd2
    } state_t;

    // Only floors below N_FLOORS can ever latch a call.
    localparam logic [8:0] MASK9      = (9'd1 << N_FLOORS) - 9'd1;
    localparam logic [7:0] FLOOR_MASK = MASK9[7:0];

    state_t     state;
    logic [7:0] sync1;
    logic [7:0] sync2;
    logic [7:0] filt;
    logic [7:0] prev;
    logic [7:0] rise;
    logic [7:0] clr;
    logic [8:0] settle;

    assign fsm_state = state;

    // Two-flop synchronizer on the raw buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 8'd0;
            sync2 <= 8'd0;
        end else begin
            sync1 <= call_btn;
            sync2 <= sync1;
        end
    end

`ifdef CALL_DISPATCHER_DEBOUNCE_EN
    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
    // Edges are ignored until the debounced level has had time to reflect a
    // button held through reset.
    localparam logic [8:0] SETTLE_INIT = 9'(DEB_CYCLES + 3);

    logic [7:0] deb_level;
    logic [7:0] deb_cnt [8];

    // Per-bit debounce: a new level is accepted on its DEB_CYCLES-th
    // consecutive sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_level <= 8'd0;
            for (int i = 0; i < 8; i++) deb_cnt[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (sync2[i] == deb_level[i]) begin
                    deb_cnt[i] <= 8'd0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_level[i] <= sync2[i];
                    deb_cnt[i]   <= 8'd0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign filt = deb_level;
`else
    // Edges are ignored until the synchronizer and edge register have
    // caught up with a button held through reset.
    localparam logic [8:0] SETTLE_INIT = 9'd3;

    assign filt = sync2;
`endif

    // Post-reset settle window and edge-detect history.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle <= SETTLE_INIT;
            prev   <= 8'd0;
        end else begin
            prev <= filt;
            if (settle != 9'd0) settle <= settle - 9'd1;
        end
    end

    assign rise = filt & ~prev & FLOOR_MASK & {8{settle == 9'd0}};
    assign clr  = doors_open ? (8'd1 << cur_floor) : 8'd0;

    // Pending latch: set on rising edge, clear at the open-door floor; the
    // clear wins for the same bit so a press at an open door is discarded.
    always_ff @(posedge clk) begin
        if (rst) pending <= 8'd0;
        else     pending <= (pending | rise) & ~clr & FLOOR_MASK;
    end

    logic       any_up;
    logic       any_down;
    logic [2:0] lo_up;
    logic [2:0] hi_down;

    // Nearest pending floor at/above and at/below the car.
    always_comb begin
        any_up   = 1'b0;
        any_down = 1'b0;
        lo_up    = 3'd0;
        hi_down  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i] && (3'(i) >= cur_floor)) begin
                any_up = 1'b1;
                lo_up  = 3'(i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (pending[i] && (3'(i) <= cur_floor)) begin
                any_down = 1'b1;
                hi_down  = 3'(i);
            end
        end
    end

    // Sweep scheduler with registered outputs, one cycle behind pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            target_floor <= 3'd0;
            target_valid <= 1'b0;
            dir_up       <= 1'b1;
        end else if (pending == 8'd0) begin
            state        <= IDLE;
            target_valid <= 1'b0;
        end else begin
            target_valid <= 1'b1;
            case (state)
                SWEEP_DOWN: begin
                    if (any_down) begin
                        target_floor <= hi_down;
                        dir_up       <= 1'b0;
                    end else begin
                        state        <= SWEEP_UP;
                        target_floor <= lo_up;
                        dir_up       <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and SWEEP_UP both prefer the upward direction.
                    if (any_up) begin
                        state        <= SWEEP_UP;
                        target_floor <= lo_up;
                        dir_up       <= 1'b1;
                    end else begin
                        state        <= SWEEP_DOWN;
                        target_floor <= hi_down;
                        dir_up       <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_call_dispatcher.sv
// Directed bench for call_dispatcher; a second instance uses N_FLOORS=6.
module tb_call_dispatcher;

`ifdef CALL_DISPATCHER_DEBOUNCE_EN
    localparam int LAT = 16 + 3;
`else
    localparam int LAT = 3;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] call_btn;
    logic [2:0] cur_floor;
    logic       doors_open;
    logic [2:0] target_floor;
    logic       target_valid;
    logic       dir_up;
    logic [7:0] pending;
    logic [1:0] fsm_state;
    logic [2:0] target_floor6;
    logic       target_valid6;
    logic       dir_up6;
    logic [7:0] pending6;
    logic [1:0] fsm_state6;

    int checks = 0;
    int errors = 0;

    call_dispatcher #(.N_FLOORS(8), .DEB_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .call_btn(call_btn), .cur_floor(cur_floor),
        .doors_open(doors_open), .target_floor(target_floor),
        .target_valid(target_valid), .dir_up(dir_up), .pending(pending),
        .fsm_state(fsm_state)
    );

    call_dispatcher #(.N_FLOORS(6), .DEB_CYCLES(16)) dut6 (
        .clk(clk), .rst(rst), .call_btn(call_btn), .cur_floor(cur_floor),
        .doors_open(doors_open), .target_floor(target_floor6),
        .target_valid(target_valid6), .dir_up(dir_up6), .pending(pending6),
        .fsm_state(fsm_state6)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; call_btn = 8'h00; cur_floor = 3'd0; doors_open = 1'b0;
        tick(2);
        check("rst_pending", 32'(pending), 32'h00);
        check("rst_valid", 32'(target_valid), 32'h0);
        check("rst_dir", 32'(dir_up), 32'h1);
        check("rst_target", 32'(target_floor), 32'h0);
        check("rst_state", 32'(fsm_state), 32'h0);
        rst = 1'b0;
        tick(LAT + 1);

        // Single call at floor 5 from floor 0
        call_btn = 8'h20;
        tick(LAT - 1);
        check("t1_pend_early", 32'(pending), 32'h00);
        tick(1);
        check("t1_pend_set", 32'(pending), 32'h20);
        check("t1_valid_lat", 32'(target_valid), 32'h0);
        tick(1);
        check("t1_target", 32'(target_floor), 32'h5);
        check("t1_valid", 32'(target_valid), 32'h1);
        check("t1_dir", 32'(dir_up), 32'h1);
        check("t1_state", 32'(fsm_state), 32'h1);
        call_btn = 8'h00;
        cur_floor = 3'd5; doors_open = 1'b1;
        tick(1);
        check("t1_clear", 32'(pending), 32'h00);
        doors_open = 1'b0;
        tick(1);
        check("t1_idle", 32'(fsm_state), 32'h0);
        check("t1_idle_valid", 32'(target_valid), 32'h0);
        tick(LAT + 2);

        // Floors 1 and 6 from floor 3: up first, then reverse
        cur_floor = 3'd3; call_btn = 8'h42;
        tick(LAT);
        check("t2_pend", 32'(pending), 32'h42);
        tick(1);
        check("t2_state_up", 32'(fsm_state), 32'h1);
        check("t2_target6", 32'(target_floor), 32'h6);
        call_btn = 8'h00;
        cur_floor = 3'd6; doors_open = 1'b1;
        tick(1);
        check("t2_pend_02", 32'(pending), 32'h02);
        check("t2_target_hold", 32'(target_floor), 32'h6);
        tick(1);
        check("t2_state_down", 32'(fsm_state), 32'h2);
        check("t2_target1", 32'(target_floor), 32'h1);
        check("t2_dir_down", 32'(dir_up), 32'h0);
        check("t2_valid", 32'(target_valid), 32'h1);
        cur_floor = 3'd1;
        tick(1);
        check("t2_clear", 32'(pending), 32'h00);
        doors_open = 1'b0;
        tick(1);
        check("t2_idle", 32'(fsm_state), 32'h0);
        check("t2_dir_hold", 32'(dir_up), 32'h0);
        tick(LAT + 2);

        // Press at the floor with doors open is discarded
        cur_floor = 3'd2; doors_open = 1'b1; call_btn = 8'h04;
        tick(LAT + 2);
        check("t3_pend", 32'(pending), 32'h00);
        check("t3_valid", 32'(target_valid), 32'h0);
        call_btn = 8'h00;
        tick(LAT + 2);
        doors_open = 1'b0;
        tick(1);
        check("t3_pend_after", 32'(pending), 32'h00);

        // Set of bit 7 and clear of bit 4 on the same edge
        cur_floor = 3'd0; call_btn = 8'h10;
        tick(LAT);
        check("t4_pend10", 32'(pending), 32'h10);
        call_btn = 8'h80;
        tick(LAT - 1);
        cur_floor = 3'd4; doors_open = 1'b1;
        tick(1);
        check("t4_set_clr", 32'(pending), 32'h80);
        // Held level must not re-set after clearing
        cur_floor = 3'd7;
        tick(1);
        check("t4_clr7", 32'(pending), 32'h00);
        doors_open = 1'b0;
        tick(LAT + 3);
        check("t4_held", 32'(pending), 32'h00);
        call_btn = 8'h00;
        tick(LAT + 2);
        call_btn = 8'h80;
        tick(LAT);
        check("t4_repress", 32'(pending), 32'h80);
        check("t6_pend6", 32'(pending6), 32'h00);
        check("t6_valid6", 32'(target_valid6), 32'h0);
        call_btn = 8'h00; doors_open = 1'b1;
        tick(1);
        doors_open = 1'b0;
        tick(LAT + 2);

        // Reset mid-sweep with buttons held
        cur_floor = 3'd0; call_btn = 8'h84;
        tick(LAT + 1);
        check("t5_pend", 32'(pending), 32'h84);
        check("t5_state", 32'(fsm_state), 32'h1);
        check("t5_target", 32'(target_floor), 32'h2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_rst_pend", 32'(pending), 32'h00);
        check("t5_rst_valid", 32'(target_valid), 32'h0);
        check("t5_rst_dir", 32'(dir_up), 32'h1);
        check("t5_rst_state", 32'(fsm_state), 32'h0);
        check("t5_rst_target", 32'(target_floor), 32'h0);
        tick(LAT + 4);
        check("t5_held_pend", 32'(pending), 32'h00);
        check("t5_held_valid", 32'(target_valid), 32'h0);
        call_btn = 8'h00;
        tick(LAT + 2);
        call_btn = 8'h04;
        tick(LAT);
        check("t5_new_press", 32'(pending), 32'h04);
        call_btn = 8'h00;
        tick(1);
        check("t5_new_target", 32'(target_floor), 32'h2);
        check("t5_new_valid", 32'(target_valid), 32'h1);
        cur_floor = 3'd2; doors_open = 1'b1;
        tick(1);
        doors_open = 1'b0;
        tick(LAT + 2);

`ifdef CALL_DISPATCHER_DEBOUNCE_EN
        // Bouncing input never settles long enough
        cur_floor = 3'd0;
        for (int k = 0; k < 20; k++) begin
            call_btn = (k % 2 == 0) ? 8'h10 : 8'h00;
            tick(5);
        end
        check("t7_bounce", 32'(pending[4]), 32'h0);
        call_btn = 8'h10;
        tick(20);
        check("t7_stable", 32'(pending[4]), 32'h1);
        call_btn = 8'h00;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/call_dispatcher.md
CALL_DISPATCHER -- requirements
Module: call_dispatcher

Interface
REQ-001 SHALL have parameter N_FLOORS, default 8, number of served floors (1..8); floor index width fixed at 3 bits.
REQ-002 SHALL have parameter DEB_CYCLES, default 16, stable-level count for the debounce filter (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port call_btn  input  8  raw asynchronous hall/cab call buttons, bit i = floor i, active-high.
REQ-006 SHALL have port cur_floor  input  3  floor the car currently occupies, from the lift controller.
REQ-007 SHALL have port doors_open  input  1  car doors open at cur_floor, from the lift controller.
REQ-008 SHALL have port target_floor  output  3  floor the lift controller is commanded to move to.
REQ-009 SHALL have port target_valid  output  1  target_floor holds a pending request.
REQ-010 SHALL have port dir_up  output  1  current sweep direction, 1 = up, 0 = down.
REQ-011 SHALL have port pending  output  8  latched outstanding calls, one bit per floor, for LED display.

Function
REQ-012 Each call_btn bit SHALL pass through a two-flop synchronizer before any other use.
REQ-013 A synchronized rising edge on bit i SHALL set pending[i]; a level held high SHALL NOT re-set the bit after it is cleared.
REQ-014 Bits i >= N_FLOORS SHALL be ignored; pending[i] for those bits SHALL stay 0.
REQ-015 pending[cur_floor] SHALL clear on the edge where doors_open=1; a new press on cur_floor while doors_open=1 SHALL be discarded.
REQ-016 Set of one bit and clear of another in the same cycle SHALL both take effect.
REQ-017 Scheduler FSM SHALL have states IDLE, SWEEP_UP, SWEEP_DOWN, all registered.
REQ-018 IDLE: target_valid=0; on pending!=0 go to SWEEP_UP if any pending floor >= cur_floor, else SWEEP_DOWN.
REQ-019 SWEEP_UP: target_floor = lowest pending floor >= cur_floor; if none, go to SWEEP_DOWN; if pending==0, go to IDLE.
REQ-020 SWEEP_DOWN: target_floor = highest pending floor <= cur_floor; if none, go to SWEEP_UP; if pending==0, go to IDLE.
REQ-021 target_floor, target_valid, dir_up SHALL be registered and reflect pending/cur_floor with exactly one cycle latency.
REQ-022 Without debounce, pending[i] SHALL be 1 after the 3rd rising edge at which call_btn[i] is sampled high.
REQ-023 dir_up SHALL hold its last value in IDLE; comparisons SHALL be unsigned 3-bit with no wrap-around.

Reset
REQ-024 While rst=1 at a rising edge: state=IDLE, pending=0, target_floor=0, target_valid=0, dir_up=1, synchronizers and debounce counters=0.
REQ-025 rst asserted mid-sweep SHALL drop all outstanding calls; buttons held through reset SHALL NOT register until released and pressed again.

Configuration
REQ-026 Macro CALL_DISPATCHER_DEBOUNCE_EN defined: each synchronized bit SHALL be accepted only after DEB_CYCLES consecutive equal samples; pending[i] sets DEB_CYCLES edges later than REQ-022.
REQ-027 Macro undefined: no debounce counters SHALL exist; edge detect works directly on synchronizer output per REQ-022.

Verification
REQ-028 Reset, cur_floor=0, pulse call_btn[5] 4 cycles (macro off) -> pending=8'h20 after 3rd edge, target_floor=5, target_valid=1, dir_up=1 next cycle.
REQ-029 cur_floor=3, pending floors 1,6 set, state SWEEP_UP -> target_floor=6; drive cur_floor=6, doors_open=1 -> pending=8'h02, next cycle SWEEP_DOWN, target_floor=1, dir_up=0.
REQ-030 cur_floor=2, doors_open=1, press call_btn[2] -> pending[2] stays 0, target_valid stays 0.
REQ-031 Macro on, DEB_CYCLES=16: call_btn[4] toggled every 5 cycles for 100 cycles -> pending[4]=0; then held 20 cycles -> pending[4]=1.
REQ-032 Pending floors 2,7 in SWEEP_UP, assert rst one cycle -> pending=0, target_valid=0, dir_up=1, state IDLE next cycle.
REQ-033 N_FLOORS=6, press call_btn[7] -> pending stays 0, target_valid stays 0.
